softmax_out_wr: RTL

- Downstream neighbour of the softmax core. Absorbs the core's Tout-wide result stream, which has valid only and no ready.
- Buffers the stream in an internal FIFO and writes it to DDR as AXI-style write bursts (AW + W channels).
- Bursts follow the pixel-major / channel-group-minor output layout. The block signals completion to the layer controller.

---
 rtl/softmax_out_wr.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/softmax_out_wr.sv
`default_nettype none
//----------------------------------------------------------------------------
// softmax_out_wr - result FIFO plus AW/W burst writer for softmax output. Rev 1.0
//----------------------------------------------------------------------------
module softmax_out_wr #(
  parameter int DW         = 16,
  parameter int TOUT       = 8,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    pix_stride,
  input  logic [CNT_W-1:0]     num_pix,
  input  logic [CNT_W-1:0]     ch_words,
  input  logic [DW*TOUT-1:0]   dat_in,
  input  logic                 dat_in_vld,
  output logic                 fifo_afull,
  output logic [ADDR_W-1:0]    aw_addr,
  output logic [7:0]           aw_len,
  output logic                 aw_vld,
  input  logic                 aw_rdy,
  output logic [DW*TOUT-1:0]   w_dat,
  output logic                 w_vld,
  output logic                 w_last,
  input  logic                 w_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_err
);

  localparam int                WW         = DW * TOUT;
  localparam int                PW         = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WW / 8);
  localparam logic [CNT_W-1:0]  BL_CNT     = CNT_W'(BURST_LEN);
  localparam logic [PW:0]       FULL_CNT   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]       AFULL_CNT  = (PW + 1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_NEXT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   stride_q, stride_d, pix_addr_q, pix_addr_d, addr_q, addr_d;
  logic [CNT_W-1:0]    num_pix_q, num_pix_d, ch_words_q, ch_words_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d, word_cnt_q, word_cnt_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;

  logic                full, empty, pop, push_ok;
  logic [CNT_W-1:0]    remaining, pix_next;
  logic [7:0]          len_m1;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign w_vld   = (state_q == S_W) && !empty;
  assign pop     = w_vld && w_rdy;
  // A full FIFO can still accept a word in the same cycle the head leaves.
  assign push_ok = dat_in_vld && (!full || pop);

  assign remaining = ch_words_q - word_cnt_q;
  assign len_m1    = (remaining >= BL_CNT) ? 8'(BURST_LEN - 1) : 8'(remaining - CNT_W'(1));

  assign aw_vld     = (state_q == S_AW);
  assign aw_addr    = aw_vld ? addr_q : '0;
  assign aw_len     = aw_vld ? len_m1 : '0;
  assign w_dat      = w_vld ? mem_q[rd_ptr_q] : '0;
  assign w_last     = w_vld && (beat_cnt_q == 8'd0);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign ovf_err    = ovf_q;
  assign fifo_afull = (count_q >= AFULL_CNT);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (!push_ok && pop) count_d = count_q - (PW + 1)'(1);
  end

  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    num_pix_d  = num_pix_q;
    ch_words_d = ch_words_q;
    pix_addr_d = pix_addr_q;
    addr_d     = addr_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    ovf_d      = ovf_q;
    pix_next   = pix_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          stride_d   = pix_stride;
          num_pix_d  = num_pix;
          ch_words_d = ch_words;
          pix_addr_d = base_addr;
          addr_d     = base_addr;
          pix_cnt_d  = '0;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = S_AW;
        end
      end
      S_AW: begin
        if (aw_rdy) begin
          beat_cnt_d = len_m1;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (pop) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          addr_d     = addr_q + WORD_BYTES;
          if (beat_cnt_q == 8'd0) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        // Pixel boundary: restart the word address from the next pixel base.
        if (word_cnt_q == ch_words_q) begin
          pix_next   = pix_cnt_q + CNT_W'(1);
          word_cnt_d = '0;
          pix_cnt_d  = pix_next;
          pix_addr_d = pix_addr_q + stride_q;
          addr_d     = pix_addr_q + stride_q;
        end
        state_d = (pix_next == num_pix_q) ? S_DONE : S_AW;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (dat_in_vld && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dat_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      stride_q   <= '0;
      num_pix_q  <= '0;
      ch_words_q <= '0;
      pix_addr_q <= '0;
      addr_q     <= '0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      stride_q   <= stride_d;
      num_pix_q  <= num_pix_d;
      ch_words_q <= ch_words_d;
      pix_addr_q <= pix_addr_d;
      addr_q     <= addr_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire
